apb_uart_tx: RTL
================

Name: apb_uart_tx

Overview:
- APB slave UART transmitter with a byte FIFO.
- Sits downstream of the apb_master bridge on the 0x4000_xxxx peripheral bus, beside the system timer.
- The core writes bytes over APB; the block serialises them 8N1, LSB first, on TX.
- Raises a level interrupt when enabled and all queued data has been sent.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 104, reset value of BAUDDIV (12 MHz / 115200).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- PSEL  input  1  APB select, pre-decoded by the SoC
- PENABLE  input  1  APB access phase
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  4  byte address within the block
- PWDATA  input  32  write data
- PRDATA  output  32  read data
- PREADY  output  1  transfer complete
- TX  output  1  serial line, idles high
- INTR  output  1  TX-done interrupt, level

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high; on reset all state clears at the next rising edge of `clk`.
- APB:
  - PREADY is constant 1 (zero wait states).
  - An access is the cycle where PSEL & PENABLE.
  - Writes commit at the clock edge ending that access cycle.
  - PRDATA is combinational from the registers when PSEL=1, and 0 otherwise.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map:
  - 0x0 TXDATA (W): PWDATA[7:0] is pushed into the FIFO. Reads return 0.
  - 0x4 STATUS (R):
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[15:8] FIFO level (0..FIFO_DEPTH).
    - Writing 1 to bit3 clears overflow.
  - 0x8 BAUDDIV (RW): bits[15:0] give the bit period in clk cycles. A value of 0 is treated as 1. Reset value is DEFAULT_DIV.
  - 0xC CTRL (RW): bit0 TX enable, bit1 IRQ enable. Resets to 0.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A push to a full FIFO with no simultaneous pop is dropped and sets overflow. Count is unchanged.
- TX FSM: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: TX=1. When enable=1 and FIFO not empty, pop the head into the shift register; next state START, baud counter loaded.
  - START: TX=0 for one bit period.
  - DATA: 8 bit periods, LSB first. A 3-bit index counts 0..7.
  - STOP: TX=1 for one bit period, then IDLE.
  - Back-to-back frames: if data is available, the exit from STOP pops in the same cycle, so the next START begins immediately.
- Bit timing:
  - The baud counter counts down from BAUDDIV-1 to 0; reaching 0 ends the bit.
  - A BAUDDIV write mid-frame takes effect at the next bit boundary.
- Enable cleared mid-frame: the current frame completes, then the FSM stays in IDLE.
- TX is registered, so the first START cycle is observed one cycle after the pop.
- INTR = irq_en & empty & ~busy, registered (one cycle lag).
- Reset values (including reset mid-frame):
  - TX=1, FIFO emptied, overflow=0, FSM=IDLE.
  - INTR=0, PRDATA=0 (when PSEL=0), PREADY=1.
  - BAUDDIV=DEFAULT_DIV, CTRL=0.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined:
  - CTRL bit2 = parity enable, CTRL bit3 = odd (1) / even (0).
  - With parity enabled, a PARITY state between DATA and STOP sends the XOR of the 8 data bits, inverted if odd. The frame becomes 11 bits.
- When undefined:
  - CTRL bits[3:2] read 0 and ignore writes.
  - No PARITY state exists; frames are always 10 bits.

Test Plan:
1. Reset, then read all registers → STATUS=0x0000_0002, BAUDDIV=104, CTRL=0, TX=1, INTR=0.
2. BAUDDIV=4, CTRL=1, write TXDATA 0xA5 → TX shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each exactly 4 cycles; busy=1 throughout, then returns to 0.
3. CTRL=0, write 9 bytes with FIFO_DEPTH=8 → level=8, full=1, overflow=1. Write 0x8 to STATUS → overflow=0.
4. BAUDDIV=2, CTRL=3, write 0x55 and 0x0F → frames are contiguous with no idle gap between STOP and START; INTR rises 1 cycle after the second STOP ends.
5. Assert rst during the DATA state of a frame → next edge TX=1, level=0, FSM IDLE; no further bits are transmitted.
6. With UART_PARITY_EN defined: CTRL=0x5 (enable, parity, even), BAUDDIV=2, send 0x07 → parity bit = 1, then stop. Repeat with CTRL=0xD (odd) → parity bit = 0.

Source files
------------

// File: rtl/apb_uart_tx_if.sv
// apb_uart_tx_if: APB bus bundle between the peripheral bridge and the UART.
// The master side drives the request, the slave side returns data and ready.
interface apb_uart_tx_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB-programmed 8N1 UART transmitter with a byte FIFO.
// Define UART_PARITY_EN to add the optional parity bit (CTRL bits 2/3).
module apb_uart_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic         clk,
    input  logic         rst,
    apb_uart_tx_if.slave apb,
    output logic         TX,
    output logic         INTR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   baud_div;
    logic [15:0]   baud_cnt;
    logic [15:0]   bit_len;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          tx_en;
    logic          irq_en;
    logic          overflow;
`ifdef UART_PARITY_EN
    logic          par_en;
    logic          par_odd;
`endif
    logic          access;
    logic          wr;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          bit_end;
    logic          tx_d;
    logic [31:0]   rdata;
    logic          unused_pwdata;

    assign access  = apb.PSEL & apb.PENABLE;
    assign wr      = access & apb.PWRITE;
    assign push    = wr && (apb.PADDR == 4'h0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign busy    = (state != S_IDLE);
    assign bit_len = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign bit_end = busy && (baud_cnt == 16'd0);

    assign unused_pwdata = ^apb.PWDATA[31:16];

    // Configuration registers and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div <= DEFAULT_DIV;
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
`ifdef UART_PARITY_EN
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
`endif
        end else begin
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (wr) begin
                case (apb.PADDR)
                    4'h4: if (apb.PWDATA[3]) overflow <= 1'b0;
                    4'h8: baud_div <= apb.PWDATA[15:0];
                    4'hC: begin
                        tx_en   <= apb.PWDATA[0];
                        irq_en  <= apb.PWDATA[1];
`ifdef UART_PARITY_EN
                        par_en  <= apb.PWDATA[2];
                        par_odd <= apb.PWDATA[3];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // FIFO storage; slots are only read while count marks them valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= apb.PWDATA[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pop) state_next = S_START;
            S_START: if (bit_end) state_next = S_DATA;
            S_DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_next = par_en ? S_PARITY : S_STOP;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (bit_end) state_next = S_STOP;
`endif
            S_STOP:  if (bit_end) state_next = pop ? S_START : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: line level and FIFO pop (STOP exit pops for back-to-back)
    always_comb begin
        tx_d = 1'b1;
        pop  = 1'b0;
        case (state)
            S_IDLE:   pop  = tx_en && !empty;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift[bit_idx];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = (^shift) ^ par_odd;
`endif
            S_STOP:   pop  = bit_end && tx_en && !empty;
            default:  ;
        endcase
    end

    // Shift register, bit index and baud countdown; BAUDDIV reloads per bit
    always_ff @(posedge clk) begin
        if (rst) begin
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else if (pop) begin
            shift    <= mem[rd_ptr];
            bit_idx  <= '0;
            baud_cnt <= bit_len - 16'd1;
        end else if (busy) begin
            if (bit_end) begin
                baud_cnt <= bit_len - 16'd1;
                if (state == S_DATA) bit_idx <= bit_idx + 3'd1;
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end
        end
    end

    // Registered line driver and level interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            TX   <= 1'b1;
            INTR <= 1'b0;
        end else begin
            TX   <= tx_d;
            INTR <= irq_en & empty & ~busy;
        end
    end

    // Register read mux
    always_comb begin
        rdata = '0;
        case (apb.PADDR)
            4'h4: rdata = {16'h0, 8'(count), 4'h0,
                           overflow, busy, empty, full};
            4'h8: rdata = {16'h0, baud_div};
`ifdef UART_PARITY_EN
            4'hC: rdata = {28'h0, par_odd, par_en, irq_en, tx_en};
`else
            4'hC: rdata = {30'h0, irq_en, tx_en};
`endif
            default: rdata = '0;
        endcase
    end

    assign apb.PRDATA = apb.PSEL ? rdata : 32'h0;
    assign apb.PREADY = 1'b1;
endmodule
